// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register, issues instruction reads,
// buffers one fetched word for decode, handles redirects and HALT.
module fetch_sequencer #(
    parameter int unsigned       WIDTH       = 16,
    parameter logic [WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_current,
    output logic [WIDTH-1:0] pc_next,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             stall,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             halted
);

    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic             valid_q, valid_d;

    logic accept;
    logic space;
    logic is_halt;

    assign accept  = valid_q & ~stall;
    assign space   = ~valid_q | accept;
    assign is_halt = (mem_data[WIDTH-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= START;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        mem_req = 1'b0;
        pc_next = pc_current;
        unique case (state_q)
            START: begin
                pc_next = RESET_PC;
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_next = redirect_target;
                    valid_d = 1'b0;
                end else begin
                    mem_req = space;
                    if (space && mem_ready) begin
                        instr_d = mem_data;
                        ipc_d   = pc_current;
                        valid_d = 1'b1;
                        if (is_halt) begin
                            state_d = HALT;
                        end else begin
                            pc_next = pc_current + TWO;
                        end
                    end else if (accept) begin
                        valid_d = 1'b0;
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_next = redirect_target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (accept) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                pc_next = RESET_PC;
                state_d = START;
            end
        endcase
    end

    assign mem_addr    = pc_current;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign pc_plus2    = ipc_q + TWO;
    assign halted      = (state_q == HALT);

endmodule
